// File: rtl/egress_scheduler.sv
// egress_scheduler: weighted round-robin pop arbiter for four class FIFOs feeding one egress port.
// Ports: clk, reset_L (async active-low); init loads weight0..3 and restarts arbitration;
// fifo_empty0..3 / data_in0..3 / valid0..3 come from the FIFOs; out_ready gates popping;
// pop0..3 are one-hot read strobes; data_out/ch_out/valid_out form the egress port; idle flags quiescence.
module egress_scheduler #(
  parameter int DATA_SIZE = 12,
  parameter int WEIGHT_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  input  logic [WEIGHT_W-1:0]  weight0,
  input  logic [WEIGHT_W-1:0]  weight1,
  input  logic [WEIGHT_W-1:0]  weight2,
  input  logic [WEIGHT_W-1:0]  weight3,
  input  logic                 fifo_empty0,
  input  logic                 fifo_empty1,
  input  logic                 fifo_empty2,
  input  logic                 fifo_empty3,
  input  logic [DATA_SIZE-1:0] data_in0,
  input  logic [DATA_SIZE-1:0] data_in1,
  input  logic [DATA_SIZE-1:0] data_in2,
  input  logic [DATA_SIZE-1:0] data_in3,
  input  logic                 valid0,
  input  logic                 valid1,
  input  logic                 valid2,
  input  logic                 valid3,
  input  logic                 out_ready,
  output logic                 pop0,
  output logic                 pop1,
  output logic                 pop2,
  output logic                 pop3,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic [1:0]           ch_out,
  output logic                 idle
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, inflight_ch_q, ch_out_q, sel, idx, pop_ch;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [WEIGHT_W-1:0] w_q [4];
  logic [DATA_SIZE-1:0] data_out_q;
  logic [DATA_SIZE-1:0] din [4];
  logic [3:0] empty, valid, pop;
  logic inflight_v_q, valid_out_q, found, stay, pop_v, emit;
  assign empty = {fifo_empty3, fifo_empty2, fifo_empty1, fifo_empty0};
  assign valid = {valid3, valid2, valid1, valid0};
  assign din = '{data_in0, data_in1, data_in2, data_in3};
  always_comb begin
    sel = ptr_q;
    idx = ptr_q;
    found = 1'b0;
    // scan backwards so the nearest non-empty channel after ptr wins; k=4 wraps back to ptr itself
    for (int k = 4; k >= 1; k--) begin
      idx = ptr_q + 2'(k);
      if (!empty[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
    stay = !empty[ptr_q] && credit_q != '0;
    pop_v = state_q == RUN && !init && out_ready && (stay || found);
    pop_ch = stay ? ptr_q : sel;
    pop = pop_v ? 4'b0001 << pop_ch : 4'b0000;
    state_d = init ? RUN : state_q;
    ptr_d = init ? 2'd3 : (pop_v && !stay) ? sel : ptr_q;
    // a fresh quantum grants weight-1 further pops; weight 0 behaves as weight 1
    credit_d = init ? '0 : !pop_v ? credit_q : stay ? credit_q - WEIGHT_W'(1) :
               (w_q[sel] == '0 ? '0 : w_q[sel] - WEIGHT_W'(1));
  end
  assign emit = inflight_v_q && valid[inflight_ch_q];
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      ptr_q <= '0;
      credit_q <= '0;
      w_q <= '{default: '0};
      inflight_v_q <= 1'b0;
      inflight_ch_q <= '0;
      valid_out_q <= 1'b0;
      data_out_q <= '0;
      ch_out_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      credit_q <= credit_d;
      if (init) w_q <= '{weight0, weight1, weight2, weight3};
      inflight_v_q <= pop_v;
      inflight_ch_q <= pop_ch;
      valid_out_q <= emit;
      if (emit) begin
        data_out_q <= din[inflight_ch_q];
        ch_out_q <= inflight_ch_q;
      end
    end
  end
  assign {pop3, pop2, pop1, pop0} = pop;
  assign data_out = data_out_q;
  assign ch_out = ch_out_q;
  assign valid_out = valid_out_q;
  assign idle = state_q == IDLE || (&empty && !inflight_v_q && !valid_out_q);
endmodule

// File: tb/tb_egress_scheduler.sv
// tb_egress_scheduler: directed bench for egress_scheduler with a behavioural four-FIFO model.
module tb_egress_scheduler;
  localparam int DW = 12;
  localparam int WW = 3;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  logic init = 1'b0;
  logic out_ready = 1'b0;
  logic [WW-1:0] w [4] = '{default: '0};
  logic [DW-1:0] din [4] = '{default: '0};
  logic vin [4] = '{default: 1'b0};
  logic e [4];
  int cnt [4] = '{default: 0};
  int seq [4] = '{default: 0};
  logic pop0, pop1, pop2, pop3, valid_out, idle;
  logic [DW-1:0] data_out;
  logic [1:0] ch_out;
  logic [DW-1:0] q [$];
  logic [DW-1:0] last_w = '0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  assign e[0] = cnt[0] == 0;
  assign e[1] = cnt[1] == 0;
  assign e[2] = cnt[2] == 0;
  assign e[3] = cnt[3] == 0;

  egress_scheduler #(.DATA_SIZE(DW), .WEIGHT_W(WW)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .weight0(w[0]), .weight1(w[1]), .weight2(w[2]), .weight3(w[3]),
    .fifo_empty0(e[0]), .fifo_empty1(e[1]), .fifo_empty2(e[2]), .fifo_empty3(e[3]),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .valid0(vin[0]), .valid1(vin[1]), .valid2(vin[2]), .valid3(vin[3]),
    .out_ready(out_ready),
    .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
    .data_out(data_out), .valid_out(valid_out), .ch_out(ch_out), .idle(idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ep: expected popped channel (-1 none); ev: expected egress channel (-1 none); ei: expected idle (-1 skip)
  task automatic cyc(input int ep, input int ev, input int ei);
    logic [3:0] p;
    @(negedge clk);
    p = {pop3, pop2, pop1, pop0};
    chk("pop", 32'(p), ep < 0 ? 32'd0 : 32'd1 << ep);
    chk("valid_out", 32'(valid_out), 32'(ev >= 0));
    if (ev >= 0) begin
      if (q.size() > 0) last_w = q.pop_front();
      else last_w = 'x;
      chk("ch_out", 32'(ch_out), 32'(ev));
    end
    chk("data_out", 32'(data_out), 32'(last_w));
    if (ei >= 0) chk("idle", 32'(idle), 32'(ei));
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      vin[i] = p[i];
      if (p[i]) begin
        din[i] = {2'(i), 10'(seq[i])};
        seq[i]++;
        if (cnt[i] > 0) cnt[i]--;
        q.push_back(din[i]);
      end
    end
  endtask

  task automatic set_cnt(input int a, input int b, input int c, input int d);
    cnt[0] = a; cnt[1] = b; cnt[2] = c; cnt[3] = d;
  endtask

  task automatic do_init(input int a, input int b, input int c, input int d);
    w[0] = WW'(a); w[1] = WW'(b); w[2] = WW'(c); w[3] = WW'(d);
    init = 1'b1;
    cyc(-1, -1, -1);
    init = 1'b0;
  endtask

  initial begin
    cyc(-1, -1, 1);
    reset_L = 1'b1;
    cyc(-1, -1, 1);
    // WRR 2,1,1,1 with backpressure and init while a word is in flight
    set_cnt(8, 8, 8, 8);
    out_ready = 1'b1;
    do_init(2, 1, 1, 1);
    cyc(0, -1, 0);
    cyc(0, -1, -1);
    cyc(1, 0, -1);
    cyc(2, 0, -1);
    cyc(3, 1, -1);
    cyc(0, 2, -1);
    cyc(0, 3, -1);
    cyc(1, 0, -1);
    out_ready = 1'b0;
    cyc(-1, 0, -1);
    cyc(-1, 1, -1);
    cyc(-1, -1, 0);
    out_ready = 1'b1;
    cyc(2, -1, -1);
    cyc(3, -1, -1);
    cyc(0, 2, -1);
    cyc(0, 3, -1);
    cyc(1, 0, -1);
    cyc(2, 0, -1);
    init = 1'b1;
    cyc(-1, 1, -1);
    init = 1'b0;
    cyc(0, 2, -1);
    cyc(0, -1, -1);
    cyc(1, 0, -1);
    out_ready = 1'b0;
    cyc(-1, 0, -1);
    cyc(-1, 1, 0);
    // weight 0 acts as 1, empty channels skipped
    set_cnt(0, 12, 0, 12);
    out_ready = 1'b1;
    do_init(0, 3, 0, 0);
    cyc(1, -1, -1);
    cyc(1, -1, -1);
    cyc(1, 1, -1);
    cyc(3, 1, -1);
    cyc(1, 1, -1);
    cyc(1, 3, -1);
    cyc(1, 1, -1);
    cyc(3, 1, -1);
    out_ready = 1'b0;
    cyc(-1, 1, -1);
    cyc(-1, 3, -1);
    cyc(-1, -1, -1);
    // channel 0 empties mid-quantum, then refills with one word
    set_cnt(2, 8, 8, 8);
    out_ready = 1'b1;
    do_init(4, 1, 1, 1);
    cyc(0, -1, -1);
    cyc(0, -1, -1);
    cyc(1, 0, -1);
    cyc(2, 0, -1);
    cyc(3, 1, -1);
    cyc(1, 2, -1);
    cyc(2, 3, -1);
    cnt[0] = 1;
    cyc(3, 1, -1);
    cyc(0, 2, -1);
    cyc(1, 3, -1);
    set_cnt(0, 0, 0, 0);
    cyc(-1, 0, 0);
    cyc(-1, 1, 0);
    cyc(-1, -1, 1);
    // reset mid-stream discards in-flight words
    set_cnt(8, 8, 8, 8);
    do_init(1, 1, 1, 1);
    cyc(0, -1, -1);
    cyc(1, -1, -1);
    reset_L = 1'b0;
    #1;
    q.delete();
    last_w = '0;
    chk("rst_pop", 32'({pop3, pop2, pop1, pop0}), 32'd0);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_ch_out", 32'(ch_out), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    cyc(-1, -1, 1);
    reset_L = 1'b1;
    cyc(-1, -1, 1);
    cyc(-1, -1, 1);
    cyc(-1, -1, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
